// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus: the fetch stage drives req/addr; memory returns ready/rdata.
interface instr_fetch_if #(
  parameter int PC_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches one word per instruction over the imem handshake,
// holds it for decode and computes the next PC from the decoder's branch/jump outputs.
//
// state | meaning
// FETCH | imem_req=1, waiting for imem_ready
// HOLD  | instr_valid=1, waiting for decode to consume (stall=0)
module instr_fetch #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_if.master     imem,
  output logic [31:0]       instr,
  output logic [7:0]        opcode,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              branch,
  input  logic              branchNotEqual,
  input  logic              jump,
  input  logic              zero,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus4,
  output logic [15:0]       retire_count
);

  typedef enum logic {FETCH, HOLD} state_t;

  localparam logic [PC_W-1:0] PC_INIT  = {RESET_PC[PC_W-1:2], 2'b00};
  localparam logic [PC_W-1:0] JMP_MASK = PC_W'(26'h3FF_FFFF);

  state_t          state, state_nxt;
  logic            consume;
  logic            taken;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] next_pc;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    consume   = 1'b0;
    case (state)
      FETCH: if (imem.imem_ready) state_nxt = HOLD;
      HOLD: begin
        if (!stall) begin
          consume   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Request and valid are masked during reset so a reset cycle never looks like a transfer.
  assign imem.imem_req  = (state == FETCH) && !reset;
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == HOLD) && !reset;
  assign opcode         = instr[31:24];
  assign pc_plus4       = pc + PC_W'(4);

  // Jump keeps pc_plus4 above bit 26; works unchanged at the minimum PC_W of 26.
  assign jmp_tgt = (pc_plus4 & ~JMP_MASK) | PC_W'({instr[23:0], 2'b00});
  assign br_off  = {{(PC_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign taken   = (branch & zero) | (branchNotEqual & ~zero);

  always_comb begin
    next_pc = pc_plus4;
    if (jump)       next_pc = jmp_tgt;
    else if (taken) next_pc = pc_plus4 + br_off;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= PC_INIT;
      instr        <= '0;
      retire_count <= '0;
    end else begin
      if (state == FETCH && imem.imem_ready) instr <= imem.imem_rdata;
      if (consume) begin
        pc           <= next_pc;
        retire_count <= retire_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table of fetch/consume transactions plus
// hand-written reset, stall and counter-wrap sequences.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [7:0]  opcode;
  logic        instr_valid;
  logic        stall, branch, branchNotEqual, jump, zero;
  logic [31:0] pc, pc_plus4;
  logic [15:0] retire_count;

  instr_fetch_if #(.PC_W(32)) bus ();

  instr_fetch #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (bus),
    .instr          (instr),
    .opcode         (opcode),
    .instr_valid    (instr_valid),
    .stall          (stall),
    .branch         (branch),
    .branchNotEqual (branchNotEqual),
    .jump           (jump),
    .zero           (zero),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .retire_count   (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          wt;
    int          st;
    logic        br;
    logic        bne;
    logic        jmp;
    logic        zr;
    logic [31:0] nxt;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] pc;
  } sb_t;

  vec_t        vecs[19];
  sb_t         sbq[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_pc;
  logic [15:0] exp_ret;

  function automatic vec_t mk(logic [31:0] rd, int wt, int st, logic br, logic bne,
                              logic jmp, logic zr, logic [31:0] nxt);
    vec_t v;
    v.rdata = rd; v.wt = wt; v.st = st; v.br = br; v.bne = bne;
    v.jmp = jmp; v.zr = zr; v.nxt = nxt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic run_vec(input vec_t v);
    sb_t         e;
    logic [31:0] exp_op;
    chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("fetch_addr", bus.imem_addr, exp_pc);
    for (int w = 0; w < v.wt; w++) begin
      @(negedge clk); #1;
      chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
      chk("wait_addr", bus.imem_addr, exp_pc);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = v.rdata;
    sbq.push_back('{rdata: v.rdata, pc: exp_pc});
    @(negedge clk);
    bus.imem_ready = 1'b0;
    bus.imem_rdata = $urandom;
    #1;
    chk("valid_latency", {31'd0, instr_valid}, 32'd1);
    chk("req_drop", {31'd0, bus.imem_req}, 32'd0);
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    exp_op = {24'd0, e.rdata[31:24]};
    chk("instr", instr, e.rdata);
    chk("opcode", {24'd0, opcode}, exp_op);
    chk("pc", pc, e.pc);
    chk("pc_plus4", pc_plus4, e.pc + 32'd4);
    for (int k = 0; k < v.st; k++) begin
      stall = 1'b1;
      jump  = k[0];
      zero  = ~k[0];
      branch = 1'b1;
      @(negedge clk); #1;
      chk("stall_instr", instr, e.rdata);
      chk("stall_pc", pc, e.pc);
      chk("stall_retire", {16'd0, retire_count}, {16'd0, exp_ret});
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    branch = v.br; branchNotEqual = v.bne; jump = v.jmp; zero = v.zr;
    @(negedge clk);
    branch = 1'b0; branchNotEqual = 1'b0; jump = 1'b0; zero = 1'b0;
    #1;
    exp_ret = exp_ret + 16'd1;
    exp_pc  = v.nxt;
    chk("retire_count", {16'd0, retire_count}, {16'd0, exp_ret});
    chk("consume_valid", {31'd0, instr_valid}, 32'd0);
    chk("next_pc", pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // rdata, wait, stall, branch, bne, jump, zero, expected next pc
    vecs[0]  = mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0000_0004);
    vecs[1]  = mk(32'h0100_0000, 0, 0, 0, 0, 0, 0, 32'h0000_0008);
    vecs[2]  = mk(32'h2000_0001, 0, 0, 0, 0, 0, 0, 32'h0000_000C);
    vecs[3]  = mk(32'h0300_1234, 0, 0, 0, 0, 0, 0, 32'h0000_0010);
    vecs[4]  = mk(32'h2200_0040, 0, 0, 0, 0, 1, 0, 32'h0000_0100);
    vecs[5]  = mk(32'h0800_0008, 0, 0, 0, 0, 1, 0, 32'h0000_0020);
    vecs[6]  = mk(32'h1000_FFFE, 0, 0, 1, 0, 0, 1, 32'h0000_001C);
    vecs[7]  = mk(32'h0800_0008, 0, 0, 0, 0, 1, 0, 32'h0000_0020);
    vecs[8]  = mk(32'h1000_FFFE, 0, 0, 1, 0, 0, 0, 32'h0000_0024);
    vecs[9]  = mk(32'h0800_0010, 0, 0, 0, 0, 1, 0, 32'h0000_0040);
    vecs[10] = mk(32'h1400_0003, 0, 0, 0, 1, 0, 1, 32'h0000_0044);
    vecs[11] = mk(32'h0800_0010, 0, 0, 0, 0, 1, 0, 32'h0000_0040);
    vecs[12] = mk(32'h1400_0003, 0, 0, 0, 1, 0, 0, 32'h0000_0050);
    vecs[13] = mk(32'hA5A5_0007, 3, 4, 0, 0, 0, 0, 32'h0000_0054);
    vecs[14] = mk(32'h1000_0002, 0, 0, 1, 1, 0, 1, 32'h0000_0060);
    vecs[15] = mk(32'h0C00_0080, 0, 0, 1, 0, 1, 1, 32'h0000_0200);
    vecs[16] = mk(32'h1000_FF7E, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    vecs[17] = mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0000_0000);
    vecs[18] = mk(32'h1400_0001, 1, 0, 0, 1, 0, 0, 32'h0000_0008);

    reset = 1'b1; stall = 1'b0; branch = 1'b0; branchNotEqual = 1'b0;
    jump = 1'b0; zero = 1'b0; bus.imem_ready = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_retire", {16'd0, retire_count}, 32'd0);
    @(negedge clk);
    bus.imem_ready = 1'b0;
    reset = 1'b0;
    #1;
    exp_pc = 32'h0; exp_ret = 16'h0;

    for (int i = 0; i < 19; i++) run_vec(vecs[i]);

    // Counter wrap: preload 0xFFFF while idle in FETCH, then one more consume.
    force dut.retire_count = 16'hFFFF;
    #1;
    release dut.retire_count;
    exp_ret = 16'hFFFF;
    run_vec(mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, exp_pc + 32'd4));
    chk("retire_wrap", {16'd0, retire_count}, 32'd0);

    // Reset landing on an accepted handshake: the word must be dropped.
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    reset = 1'b1;
    #1;
    chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    bus.imem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_pc", pc, 32'd0);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_retire", {16'd0, retire_count}, 32'd0);
    exp_pc = 32'h0; exp_ret = 16'h0;
    run_vec(mk(32'h0000_0000, 2, 1, 0, 0, 0, 0, 32'h0000_0004));

    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 8-bit-opcode single-cycle datapath. Holds the program counter, fetches 32-bit instruction words from instruction memory over a req/ready handshake, and presents each word and its opcode (bits [31:24]) to the main decoder. It computes the next PC from the decoder's branch, branchNotEqual and jump outputs plus the ALU zero flag.

## Interface
- PC_W, 32: program counter width; at least 26.
- RESET_PC, 0: PC value after reset; bits [1:0] are forced to 0.

- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request
- imem_addr  output  PC_W  byte address of the requested word (= pc)
- imem_ready  input  1  rdata valid; sampled only while imem_req=1
- imem_rdata  input  32  instruction word
- instr  output  32  held instruction
- opcode  output  8  instr[31:24], fed to the decoder
- instr_valid  output  1  instr/opcode valid for decode
- stall  input  1  decode/execute not ready; holds the current instruction
- branch  input  1  beq decoded
- branchNotEqual  input  1  bne decoded
- jump  input  1  j decoded
- zero  input  1  ALU zero result for the current instruction
- pc  output  PC_W  address of the current instruction
- pc_plus4  output  PC_W  pc + 4, modulo 2^PC_W
- retire_count  output  16  retired-instruction counter; wraps

## Operation
- States:
  - FETCH: imem_req=1, waiting for imem_ready.
  - HOLD: instr_valid=1, waiting for consume.
- Reset (synchronous, any state):
  - pc=RESET_PC, state=FETCH.
  - instr=0, instr_valid=0, imem_req=0 during the reset cycle.
  - retire_count=0.
  - Any outstanding request is abandoned, and imem_ready in the reset cycle is ignored.
- FETCH: when imem_ready=1, instr<=imem_rdata and state<=HOLD. Otherwise remain in FETCH, keeping imem_addr stable.
- HOLD, stall=1: everything is held. branch, branchNotEqual, jump and zero are ignored.
- HOLD, stall=0 (consume):
  - pc<=next_pc, instr_valid<=0, retire_count+=1, state<=FETCH.
  - instr keeps its old value but is not valid.
- next_pc priority:
  1. jump=1: {pc_plus4[PC_W-1:26], instr[23:0], 2'b00}.
  2. Else if taken = (branch & zero) | (branchNotEqual & ~zero): pc_plus4 + (sign_extend(instr[15:0]) << 2), truncated to PC_W.
  3. Else pc_plus4.
- Simultaneous branch and branchNotEqual: taken evaluates as written; jump still wins over both.
- PC arithmetic wraps modulo 2^PC_W with no error flag. pc[1:0] is always 0.
- Branch, jump and zero inputs matter only in the consume cycle.

## Timing
- First request is in the cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC.
- imem_ready=1 in cycle N gives instr_valid=1 in cycle N+1, and imem_req=0 in N+1.
- Consume in cycle M gives imem_req=1 with the new imem_addr in cycle M+1.
- Minimum two cycles per instruction with zero-wait memory.
- Throughput with memory wait w and stall s: 2+w+s cycles per instruction.
- imem_req never drops without an imem_ready or a reset.
- opcode, pc and pc_plus4 are combinational from registers only, never from inputs.

## Test plan
- Reset then sequential fetch: RESET_PC=0, imem_ready=1 constantly, no control inputs. Required: imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses every 2 cycles; retire_count=3 after three consumes.
- Jump: pc=0x10, instr=0x22000040 (opcode 34), jump=1, consume. Required: next imem_addr=0x00000100.
- beq taken with negative offset: pc=0x20, instr[15:0]=0xFFFE, branch=1, zero=1. Required: next pc=0x1C. The same case with zero=0 gives 0x24.
- bne not taken: branchNotEqual=1, zero=1 at pc=0x40. Required: next pc=0x44. With zero=0 and offset 0x0003, next pc=0x50.
- Wait states and stall:
  - imem_ready held low for 3 cycles: imem_req and imem_addr stay stable.
  - stall=1 for 4 cycles in HOLD, with jump toggling: instr, pc and retire_count unchanged, and the jump is ignored.
  - Release stall: exactly one retire.
- Reset mid-fetch and wrap-around:
  - Reset asserted while imem_req=1 and imem_ready=1: instr_valid stays 0, pc=RESET_PC.
  - pc=0xFFFFFFFC sequential: next pc=0x00000000.
  - retire_count at 0xFFFF plus one consume: 0x0000.
